ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter: the send side of the keyboard link whose receive path already feeds the keyboard decoder.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- Drives the open-collector PS2_CLK/PS2_DATA lines through output-enable pins and reports done or error to the CPU/ALU side.
- Sits beside the receiver; while oBusy=1 the receiver must ignore line activity.

---
 rtl/ps2_host_tx.sv | 152 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command byte transmitter with filtered line inputs.
// Define PS2_TX_RESEND_EN to retry a failed transfer once before pulsing oError.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iSend,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DATA,
    output logic       oPS2_CLK_OE,
    output logic       oPS2_DATA_OE,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {IDLE, INHIBIT, REQ, BITS, PARITY, STOP, ACK, WAIT_IDLE, DONE, ERR} stateT;

    stateT state;
    logic [1:0] clkSync, dataSync;
    logic [FILTER_LEN-1:0] clkHist, dataHist;
    logic clkFilt, dataFilt, clkPrev;
    logic [IW-1:0] inhCnt;
    logic [TW-1:0] toutCnt;
    logic [3:0] bitCnt;
    logic [7:0] dataReg;
    logic parity;
    logic fall, timed, timeout, fail, canRetry;

    // Idle bus is high, so the conditioning chain resets to ones.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clkSync <= '1;
            dataSync <= '1;
            clkHist <= '1;
            dataHist <= '1;
            clkFilt <= 1'b1;
            dataFilt <= 1'b1;
            clkPrev <= 1'b1;
        end else begin
            clkSync <= {clkSync[0], iPS2_CLK};
            dataSync <= {dataSync[0], iPS2_DATA};
            clkHist <= {clkHist[FILTER_LEN-2:0], clkSync[1]};
            dataHist <= {dataHist[FILTER_LEN-2:0], dataSync[1]};
            clkFilt <= &clkHist | (clkFilt & |clkHist);
            dataFilt <= &dataHist | (dataFilt & |dataHist);
            clkPrev <= clkFilt;
        end
    end

    assign fall = clkPrev & ~clkFilt;
    assign timed = state inside {BITS, PARITY, STOP, ACK, WAIT_IDLE};
    assign timeout = timed && toutCnt == TMO_LAST;
    assign fail = timeout || (state == ACK && fall && dataFilt);

`ifdef PS2_TX_RESEND_EN
    logic retried;
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) retried <= 1'b0;
        else if (state == IDLE) retried <= 1'b0;
        else if (fail) retried <= 1'b1;
    end
    assign canRetry = !retried;
`else
    assign canRetry = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            oPS2_CLK_OE <= 1'b0;
            oPS2_DATA_OE <= 1'b0;
            oBusy <= 1'b0;
            oDone <= 1'b0;
            oError <= 1'b0;
            inhCnt <= '0;
            toutCnt <= '0;
            bitCnt <= '0;
            dataReg <= '0;
            parity <= 1'b0;
        end else begin
            oDone <= 1'b0;
            oError <= 1'b0;
            if (timed) toutCnt <= toutCnt + TW'(1);
            if (timed && fall) bitCnt <= (bitCnt == 4'd11) ? bitCnt : bitCnt + 4'd1;
            if (fail) begin
                oPS2_DATA_OE <= 1'b0;
                inhCnt <= '0;
                if (canRetry) begin
                    oPS2_CLK_OE <= 1'b1;
                    state <= INHIBIT;
                end else begin
                    oPS2_CLK_OE <= 1'b0;
                    oBusy <= 1'b0;
                    oError <= 1'b1;
                    state <= ERR;
                end
            end else begin
                case (state)
                    IDLE: if (iSend) begin
                        dataReg <= iData;
                        parity <= ~^iData;
                        oBusy <= 1'b1;
                        oPS2_CLK_OE <= 1'b1;
                        inhCnt <= '0;
                        state <= INHIBIT;
                    end
                    INHIBIT: begin
                        inhCnt <= inhCnt + IW'(1);
                        if (inhCnt == INH_LAST) begin
                            oPS2_DATA_OE <= 1'b1;
                            state <= REQ;
                        end
                    end
                    REQ: begin
                        oPS2_CLK_OE <= 1'b0;
                        toutCnt <= '0;
                        bitCnt <= '0;
                        state <= BITS;
                    end
                    BITS: if (fall) begin
                        oPS2_DATA_OE <= ~dataReg[bitCnt[2:0]];
                        if (bitCnt == 4'd7) state <= PARITY;
                    end
                    PARITY: if (fall) begin
                        oPS2_DATA_OE <= ~parity;
                        state <= STOP;
                    end
                    STOP: if (fall) begin
                        oPS2_DATA_OE <= 1'b0;
                        state <= ACK;
                    end
                    ACK: if (fall) state <= WAIT_IDLE;
                    WAIT_IDLE: if (clkFilt && dataFilt) begin
                        oDone <= 1'b1;
                        oBusy <= 1'b0;
                        state <= DONE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench with an open-collector PS/2 device model for ps2_host_tx.
module tb_ps2_host_tx;
    localparam int INH = 5000;
    localparam int TOUT = 2000;
`ifdef PS2_TX_RESEND_EN
    localparam int ATT = 2;
`else
    localparam int ATT = 1;
`endif

    typedef struct {
        bit isErr;
        bit chkByte;
        logic [7:0] b;
        logic p;
        int inh;
        int tout;
    } expT;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    logic [7:0] iData = 8'h00;
    logic iSend = 1'b0;
    logic devClk = 1'b1;
    logic devData = 1'b1;
    logic clkPad, dataPad;
    logic oPS2_CLK_OE, oPS2_DATA_OE, oBusy, oDone, oError;

    expT expQ[$];
    expT e;
    int nCmp = 0, nFail = 0, cyc = 0, run = 0, reqLen = 0, reqExit = 0, inhCount = 0, pulses = 0;
    logic [10:0] rxBits = '0;
    bit ok;
    logic s;

    assign clkPad = ~oPS2_CLK_OE & devClk;
    assign dataPad = ~oPS2_DATA_OE & devData;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TOUT), .FILTER_LEN(8)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .iData(iData),
        .iSend(iSend),
        .iPS2_CLK(clkPad),
        .iPS2_DATA(dataPad),
        .oPS2_CLK_OE(oPS2_CLK_OE),
        .oPS2_DATA_OE(oPS2_DATA_OE),
        .oBusy(oBusy),
        .oDone(oDone),
        .oError(oError)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: measures inhibit/request phases and scores every done/error pulse.
    always @(negedge Clock) begin
        if (!Reset) begin
            run = 0;
            reqLen = 0;
            inhCount = 0;
        end else begin
            if (oPS2_CLK_OE && !oPS2_DATA_OE) run++;
            else if (oPS2_CLK_OE) begin
                if (run != 0) begin
                    chk("inhibit_len", run, INH);
                    inhCount++;
                end
                run = 0;
                reqLen++;
            end else begin
                if (reqLen != 0) begin
                    chk("req_len", reqLen, 1);
                    reqExit = cyc;
                end
                run = 0;
                reqLen = 0;
            end
            if (oDone || oError) begin
                pulses++;
                chk("pending_expect", int'(expQ.size() != 0), 1);
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    chk("done_pulse", oDone, !e.isErr);
                    chk("error_pulse", oError, e.isErr);
                    chk("busy_clear", oBusy, 0);
                    chk("attempts", inhCount, e.inh);
                    if (e.chkByte) begin
                        chk("rx_byte", rxBits[7:0], e.b);
                        chk("rx_parity", rxBits[8], e.p);
                        chk("rx_stop", rxBits[9], 1);
                    end
                    if (e.tout > 0) chk("timeout_cycles", cyc - reqExit, e.tout);
                end
                inhCount = 0;
            end
        end
    end

    task automatic waitReq(output bit got);
        int n = 0;
        while (!(oPS2_CLK_OE && oPS2_DATA_OE) && n < 10000) begin
            @(negedge Clock);
            n++;
        end
        while (oPS2_CLK_OE && n < 10000) begin
            @(negedge Clock);
            n++;
        end
        got = (n < 10000);
        chk("request_seen", int'(got), 1);
    endtask

    task automatic pulse(input bit ack, input bit glitch, output logic smp);
        if (glitch) begin
            repeat (8) @(negedge Clock);
            devClk = 1'b0;
            repeat (3) @(negedge Clock);
            devClk = 1'b1;
            repeat (14) @(negedge Clock);
        end else repeat (25) @(negedge Clock);
        if (ack) begin
            devData = 1'b0;
            repeat (3) @(negedge Clock);
        end
        devClk = 1'b0;
        repeat (25) @(negedge Clock);
        smp = dataPad;
        devClk = 1'b1;
        if (ack) begin
            repeat (5) @(negedge Clock);
            devData = 1'b1;
        end
    endtask

    // mode 0: device acks, 1: no ack, 2: device never clocks
    task automatic xfer(input logic [7:0] b, input logic p, input int mode, input bit glitch, input bit hold);
        int start = pulses;
        int n = 0;
        bit got;
        logic smp;
        expQ.push_back('{mode != 0, mode != 2, b, p, (mode == 0) ? 1 : ATT, (mode == 2) ? TOUT : 0});
        rxBits = '0;
        @(negedge Clock);
        iData = b;
        iSend = 1'b1;
        if (!hold) begin
            @(negedge Clock);
            iSend = 1'b0;
        end
        for (int a = 0; a < ((mode == 0) ? 1 : ATT); a++) begin
            waitReq(got);
            if (!got) break;
            if (mode != 2) for (int k = 0; k < 11; k++) begin
                pulse(mode == 0 && k == 10, glitch && k == 3, smp);
                rxBits[k] = smp;
            end
        end
        while (pulses == start && n < 12000) begin
            @(negedge Clock);
            n++;
        end
        chk("xfer_complete", int'(pulses != start), 1);
        iSend = 1'b0;
        repeat (30) @(negedge Clock);
    endtask

    initial begin
        repeat (5) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        chk("reset_clk_oe", oPS2_CLK_OE, 0);
        chk("reset_data_oe", oPS2_DATA_OE, 0);
        chk("reset_busy", oBusy, 0);
        chk("reset_done", oDone, 0);
        chk("reset_error", oError, 0);
        repeat (20) @(negedge Clock);

        xfer(8'hED, 1'b1, 0, 1'b0, 1'b0);
        xfer(8'hF4, 1'b0, 0, 1'b0, 1'b0);
        xfer(8'h00, 1'b1, 0, 1'b0, 1'b1);
        repeat (200) @(negedge Clock);
        chk("no_second_busy", oBusy, 0);
        chk("no_second_clk_oe", oPS2_CLK_OE, 0);
        xfer(8'hED, 1'b1, 0, 1'b1, 1'b0);
        xfer(8'hFF, 1'b1, 1, 1'b0, 1'b0);
        xfer(8'hF4, 1'b0, 2, 1'b0, 1'b0);

        @(negedge Clock);
        iData = 8'hED;
        iSend = 1'b1;
        @(negedge Clock);
        iSend = 1'b0;
        rxBits = '0;
        waitReq(ok);
        if (ok) for (int k = 0; k < 5; k++) begin
            pulse(1'b0, 1'b0, s);
            rxBits[k] = s;
        end
        chk("partial_rx", rxBits[3:0], 4'hD);
        chk("busy_before_reset", oBusy, 1);
        chk("data_oe_before_reset", oPS2_DATA_OE, 1);
        #2 Reset = 1'b0;
        #1;
        chk("async_clk_oe", oPS2_CLK_OE, 0);
        chk("async_data_oe", oPS2_DATA_OE, 0);
        chk("async_busy", oBusy, 0);
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        repeat (100) @(negedge Clock);
        chk("post_reset_busy", oBusy, 0);
        chk("post_reset_clk_oe", oPS2_CLK_OE, 0);
        chk("post_reset_data_oe", oPS2_DATA_OE, 0);

        chk("queue_empty", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
